lcd_capture: RTL and testbench

LCD_CAPTURE -- requirements
Module: lcd_capture

---
 rtl/lcd_pkg.sv | 16 +
 rtl/lcd_capture_chip.sv | 54 +++++
 rtl/lcd_capture.sv | 114 +++++++++++
 tb/tb_lcd_capture.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared geometry and instruction codes for the LCD bus capture block.
// Instruction codes compare against the low six bits of an instruction byte.
package lcd_pkg;

  localparam int LCD_MODULES  = 10;
  localparam int X_PER_MODULE = 50;

  typedef enum logic [5:0] {
    CMD_DISP_OFF   = 6'h38,
    CMD_DISP_ON    = 6'h39,
    CMD_DOWN_MODE  = 6'h3A,
    CMD_UP_MODE    = 6'h3B,
    CMD_START_PAGE = 6'h3E
  } lcd_cmd_e;

endpackage

// File: rtl/lcd_capture_chip.sv
// Address state of one LCD controller: column, page, count direction and display flag.
// Instructions and data writes arrive already qualified by the top-level bus decoder.
module lcd_capture_chip
  import lcd_pkg::*;
#(
  parameter int X_PER_MODULE = lcd_pkg::X_PER_MODULE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_we,
  input  logic       data_we,
  input  logic [7:0] data,
  output logic [5:0] column,
  output logic [1:0] page,
  output logic       disp_on
);

  localparam logic [5:0] COL_LAST = 6'(X_PER_MODULE - 1);

  logic       up_mode;
  logic [5:0] low6;

  assign low6 = data[5:0];

  // Named instruction codes take priority over the set-address form.
  always_ff @(posedge clk) begin
    if (reset) begin
      column  <= '0;
      page    <= '0;
      up_mode <= 1'b1;
      disp_on <= 1'b0;
    end else if (cmd_we) begin
      case (low6)
        CMD_DISP_ON:    disp_on <= 1'b1;
        CMD_DISP_OFF:   disp_on <= 1'b0;
        CMD_UP_MODE:    up_mode <= 1'b1;
        CMD_DOWN_MODE:  up_mode <= 1'b0;
        CMD_START_PAGE: ;
        default: begin
          if (int'(low6) < X_PER_MODULE) begin
            page   <= data[7:6];
            column <= low6;
          end
        end
      endcase
    end else if (data_we) begin
      if (up_mode)
        column <= (column == COL_LAST) ? 6'd0 : column + 6'd1;
      else
        column <= (column == 6'd0) ? COL_LAST : column - 6'd1;
    end
  end

endmodule

// File: rtl/lcd_capture.sv
// Snoops a multi-module LCD bus and turns display-data writes into framebuffer writes.
// Bus pins are resynchronised; a transfer is taken on the falling edge of enable.
module lcd_capture
  import lcd_pkg::*;
#(
  parameter int LCD_MODULES  = lcd_pkg::LCD_MODULES,
  parameter int X_PER_MODULE = lcd_pkg::X_PER_MODULE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             data_pin,
  input  logic [LCD_MODULES-1:0] cs_pin,
  input  logic                   cs1_pin,
  input  logic                   rw_pin,
  input  logic                   di_pin,
  input  logic                   enable_pin,
  output logic                   fb_we,
  output logic [7:0]             fb_x,
  output logic [2:0]             fb_y,
  output logic [7:0]             fb_data,
  output logic [LCD_MODULES-1:0] display_on,
  output logic                   frame_start
);

  localparam int HALF  = LCD_MODULES / 2;
  localparam int IDX_W = $clog2(LCD_MODULES);

  logic [7:0]             data_s1, data_s2;
  logic [LCD_MODULES-1:0] cs_s1, cs_s2;
  logic                   cs1_s1, cs1_s2, rw_s1, rw_s2, di_s1, di_s2;
  logic                   en_s1, en_s2, en_s3;

  // Enable stages reset high so leaving reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      {data_s1, data_s2} <= '0;
      {cs_s1, cs_s2}     <= '0;
      {cs1_s1, cs1_s2}   <= '0;
      {rw_s1, rw_s2}     <= '0;
      {di_s1, di_s2}     <= '0;
      {en_s1, en_s2, en_s3} <= 3'b111;
    end else begin
      {data_s2, data_s1} <= {data_s1, data_pin};
      {cs_s2, cs_s1}     <= {cs_s1, cs_pin};
      {cs1_s2, cs1_s1}   <= {cs1_s1, cs1_pin};
      {rw_s2, rw_s1}     <= {rw_s1, rw_pin};
      {di_s2, di_s1}     <= {di_s1, di_pin};
      {en_s3, en_s2, en_s1} <= {en_s2, en_s1, enable_pin};
    end
  end

  logic                   bus_ev, cmd_ev, write_ev, found;
  logic [IDX_W-1:0]       wr_idx;
  logic [LCD_MODULES-1:0] cmd_sel, wr_sel;
  logic [5:0]             col [LCD_MODULES];
  logic [1:0]             pg  [LCD_MODULES];
  logic [7:0]             next_x;
  logic [2:0]             next_y;

  assign bus_ev   = en_s3 & ~en_s2 & cs1_s2 & ~rw_s2 & (|cs_s2);
  assign cmd_ev   = bus_ev & ~di_s2;
  assign write_ev = bus_ev & di_s2;
  assign cmd_sel  = {LCD_MODULES{cmd_ev}} & cs_s2;

  // Data writes go only to the lowest-numbered selected module.
  always_comb begin
    found  = 1'b0;
    wr_idx = '0;
    for (int i = 0; i < LCD_MODULES; i++) begin
      if (cs_s2[i] && !found) begin
        found  = 1'b1;
        wr_idx = IDX_W'(i);
      end
    end
    wr_sel = '0;
    if (write_ev)
      wr_sel[wr_idx] = 1'b1;
    next_x = 8'((int'(wr_idx) % HALF) * X_PER_MODULE + int'(col[wr_idx]));
    next_y = {int'(wr_idx) >= HALF, pg[wr_idx]};
  end

  for (genvar g = 0; g < LCD_MODULES; g++) begin : g_chip
    lcd_capture_chip #(.X_PER_MODULE(X_PER_MODULE)) u_chip (
      .clk     (clk),
      .reset   (reset),
      .cmd_we  (cmd_sel[g]),
      .data_we (wr_sel[g]),
      .data    (data_s2),
      .column  (col[g]),
      .page    (pg[g]),
      .disp_on (display_on[g])
    );
  end

  // Address is taken from the column before the chip advances it on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_we       <= 1'b0;
      frame_start <= 1'b0;
      fb_x        <= '0;
      fb_y        <= '0;
      fb_data     <= '0;
    end else begin
      fb_we       <= write_ev;
      frame_start <= write_ev && (next_x == 8'd0) && (next_y == 3'd0);
      if (write_ev) begin
        fb_x    <= next_x;
        fb_y    <= next_y;
        fb_data <= data_s2;
      end
    end
  end

endmodule

// File: tb/tb_lcd_capture.sv
// Self-checking bench for lcd_capture: directed bus scenarios plus random traffic
// compared against a behavioural model of the LCD controllers and framebuffer mapping.
module tb_lcd_capture;

  localparam int NMOD = lcd_pkg::LCD_MODULES;
  localparam int XPM  = lcd_pkg::X_PER_MODULE;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [7:0]      data_pin = '0;
  logic [NMOD-1:0] cs_pin = '0;
  logic            cs1_pin = 1'b0, rw_pin = 1'b0, di_pin = 1'b0, enable_pin = 1'b1;
  logic            fb_we, frame_start;
  logic [7:0]      fb_x, fb_data;
  logic [2:0]      fb_y;
  logic [NMOD-1:0] display_on;

  lcd_capture dut (
    .clk(clk), .reset(reset), .data_pin(data_pin), .cs_pin(cs_pin), .cs1_pin(cs1_pin),
    .rw_pin(rw_pin), .di_pin(di_pin), .enable_pin(enable_pin), .fb_we(fb_we), .fb_x(fb_x),
    .fb_y(fb_y), .fb_data(fb_data), .display_on(display_on), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int d;
    bit fs;
  } wr_t;

  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  // Behavioural state of every controller.
  int m_col [NMOD];
  int m_page[NMOD];
  bit m_up  [NMOD];
  bit m_disp[NMOD];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NMOD; i++) begin
      m_col[i] = 0; m_page[i] = 0; m_up[i] = 1'b1; m_disp[i] = 1'b0;
    end
  endtask

  function automatic logic [NMOD-1:0] modelDisp();
    logic [NMOD-1:0] v;
    for (int i = 0; i < NMOD; i++) v[i] = m_disp[i];
    return v;
  endfunction

  task automatic modelBus(input logic [NMOD-1:0] cs, input logic cs1, input logic rw,
                          input logic di, input logic [7:0] data, output bit we, output wr_t e);
    int low6, m;
    we = 1'b0;
    e  = '{0, 0, 0, 1'b0};
    low6 = int'(data) % 64;
    if (!cs1 || rw || cs == '0) return;
    if (!di) begin
      for (int i = 0; i < NMOD; i++) begin
        if (!cs[i]) continue;
        if (low6 == 'h39) m_disp[i] = 1'b1;
        else if (low6 == 'h38) m_disp[i] = 1'b0;
        else if (low6 == 'h3B) m_up[i] = 1'b1;
        else if (low6 == 'h3A) m_up[i] = 1'b0;
        else if (low6 == 'h3E) ;
        else if (low6 < XPM) begin
          m_page[i] = int'(data) / 64;
          m_col[i]  = low6;
        end
      end
    end else begin
      m = 0;
      while (!cs[m]) m++;
      we   = 1'b1;
      e.x  = (m % (NMOD / 2)) * XPM + m_col[m];
      e.y  = (m >= NMOD / 2 ? 4 : 0) + m_page[m];
      e.d  = int'(data);
      e.fs = (e.x == 0) && (e.y == 0);
      m_col[m] = m_up[m] ? (m_col[m] + 1) % XPM : (m_col[m] + XPM - 1) % XPM;
    end
  endtask

  // One complete bus cycle: set up pins, strobe enable low, check the write lands in E+1.
  task automatic applyStimulus(input logic [NMOD-1:0] cs, input logic cs1, input logic rw,
                               input logic di, input logic [7:0] data);
    bit  we;
    wr_t e;
    @(negedge clk);
    cs_pin = cs; cs1_pin = cs1; rw_pin = rw; di_pin = di; data_pin = data; enable_pin = 1'b1;
    repeat (2) @(negedge clk);
    modelBus(cs, cs1, rw, di, data, we, e);
    if (we) exp_q.push_back(e);
    enable_pin = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("we_early", fb_we, 1'b0);
    @(negedge clk);
    checkOutput("we_latency", fb_we, we);
    @(negedge clk);
    enable_pin = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("display_on", display_on, modelDisp());
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b1; enable_pin = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  // Every framebuffer strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (fb_we === 1'b1) begin
      if (exp_q.size() == 0) checkOutput("spurious_we", 1, 0);
      else begin
        e = exp_q.pop_front();
        checkOutput("fb_x", fb_x, e.x);
        checkOutput("fb_y", fb_y, e.y);
        checkOutput("fb_data", fb_data, e.d);
        checkOutput("frame_start", frame_start, e.fs);
      end
    end else if (frame_start !== 1'b0) begin
      checkOutput("stray_frame_start", frame_start, 0);
    end
  end

  initial begin : watchdog
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bit          we;
    wr_t         e;
    logic [7:0]  codes[5] = '{8'h38, 8'h39, 8'h3A, 8'h3B, 8'h3E};
    logic [NMOD-1:0] cs;
    logic [7:0]  d;
    logic        di;

    resetDut();
    @(negedge clk);
    checkOutput("rst_fb_we", fb_we, 0);
    checkOutput("rst_fb_x", fb_x, 0);
    checkOutput("rst_fb_y", fb_y, 0);
    checkOutput("rst_fb_data", fb_data, 0);
    checkOutput("rst_frame_start", frame_start, 0);
    checkOutput("rst_display_on", display_on, 0);

    // All modules on and counting up.
    applyStimulus('1, 1, 0, 0, 8'h39);
    applyStimulus('1, 1, 0, 0, 8'h3B);
    checkOutput("disp_all_on", display_on, {NMOD{1'b1}});

    // Module 0, page 2, three consecutive columns.
    applyStimulus(10'h001, 1, 0, 0, 8'h80);
    applyStimulus(10'h001, 1, 0, 1, 8'hAA);
    applyStimulus(10'h001, 1, 0, 1, 8'hBB);
    applyStimulus(10'h001, 1, 0, 1, 8'hCC);

    // Module 6 at the last column, wrapping to the start of its strip.
    applyStimulus(10'h040, 1, 0, 0, 8'h71);
    applyStimulus(10'h040, 1, 0, 1, 8'h55);
    applyStimulus(10'h040, 1, 0, 1, 8'h55);

    // Down-counting wrap from column 0.
    applyStimulus(10'h001, 1, 0, 0, 8'h3A);
    applyStimulus(10'h001, 1, 0, 0, 8'h00);
    applyStimulus(10'h001, 1, 0, 1, 8'h11);
    applyStimulus(10'h001, 1, 0, 1, 8'h22);
    applyStimulus(10'h001, 1, 0, 0, 8'h3B);

    // Bus disabled or read cycles are ignored, then a frame-start write.
    applyStimulus(10'h001, 0, 0, 1, 8'h99);
    applyStimulus(10'h001, 1, 1, 1, 8'h98);
    applyStimulus(10'h000, 1, 0, 1, 8'h97);
    applyStimulus(10'h001, 1, 0, 0, 8'h00);
    applyStimulus(10'h001, 1, 0, 1, 8'h5A);

    // Multiple selects: data goes to lowest index only.
    applyStimulus(10'h30C, 1, 0, 0, 8'hC5);
    applyStimulus(10'h30C, 1, 0, 1, 8'h3C);
    applyStimulus(10'h308, 1, 0, 1, 8'h3D);

    for (int n = 0; n < 160; n++) begin
      case ($urandom_range(0, 3))
        0, 1: cs = NMOD'(1) << $urandom_range(0, NMOD - 1);
        2:    cs = NMOD'($urandom);
        default: cs = ($urandom_range(0, 4) == 0) ? '0 : NMOD'($urandom);
      endcase
      di = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      if (!di && $urandom_range(0, 1) == 1) d = codes[$urandom_range(0, 4)] | 8'($urandom_range(0, 3) << 6);
      applyStimulus(cs, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, di, d);
    end

    // Back-to-back edges two cycles apart are both captured.
    applyStimulus(10'h010, 1, 0, 0, 8'h45);
    @(negedge clk);
    cs_pin = 10'h010; cs1_pin = 1; rw_pin = 0; di_pin = 1;
    modelBus(10'h010, 1, 0, 1, 8'hE1, we, e); exp_q.push_back(e);
    modelBus(10'h010, 1, 0, 1, 8'hE2, we, e); exp_q.push_back(e);
    data_pin = 8'hE1; enable_pin = 0;
    @(negedge clk); enable_pin = 1;
    @(negedge clk); data_pin = 8'hE2; enable_pin = 0;
    @(negedge clk); checkOutput("burst_we1", fb_we, 1); enable_pin = 1;
    @(negedge clk); checkOutput("burst_gap", fb_we, 0);
    @(negedge clk); checkOutput("burst_we2", fb_we, 1);
    repeat (3) @(negedge clk);

    // Reset in the middle of a transfer discards it and restores all state.
    applyStimulus(10'h008, 1, 0, 1, 8'h77);
    @(negedge clk);
    cs_pin = 10'h008; cs1_pin = 1; rw_pin = 0; di_pin = 1; data_pin = 8'h66;
    repeat (2) @(negedge clk);
    enable_pin = 0;
    @(negedge clk);
    reset = 1; enable_pin = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    modelReset();
    for (int k = 0; k < 6; k++) checkOutput("we_after_reset", fb_we, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("no_we_post_reset", fb_we, 0);
    end
    checkOutput("rst2_fb_x", fb_x, 0);
    checkOutput("rst2_fb_y", fb_y, 0);
    checkOutput("rst2_fb_data", fb_data, 0);
    checkOutput("rst2_display_on", display_on, 0);
    applyStimulus(10'h040, 1, 0, 1, 8'h0F);
    applyStimulus(10'h040, 1, 0, 1, 8'hF0);
    applyStimulus(10'h001, 1, 0, 1, 8'h01);

    repeat (4) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
